// File: rtl/cmp_arb_pkg.sv
// cmp_arb_pkg: FSM state encoding and default sizing shared by the
// comparator arbiter and its compare block.
package cmp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_OP_WIDTH  = 64;
    localparam int DEF_CMP_WIDTH = 32;

endpackage

// File: rtl/cmp_arbiter_cmp.sv
// cmp_arbiter_cmp: combinational WIDTH-bit equality comparator shared by all
// requesters through the arbiter's operand mux.
module cmp_arbiter_cmp #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq
);

    assign eq = (a == b);

endmodule

// File: rtl/cmp_arbiter.sv
// cmp_arbiter: round-robin arbiter time-sharing one CMP_WIDTH comparator for
// OP_WIDTH compares (LO pass then HI pass). Option macro: CMP_EARLY_OUT_EN.
module cmp_arbiter
    import cmp_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int OP_WIDTH  = DEF_OP_WIDTH,
    parameter int CMP_WIDTH = DEF_CMP_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*OP_WIDTH-1:0]  a_flat,
    input  logic [NUM_REQ*OP_WIDTH-1:0]  b_flat,
    output logic [NUM_REQ-1:0]           done,
    output logic                         eq,
    output logic                         busy
);

    // OP_WIDTH is expected to be exactly 2*CMP_WIDTH: two passes cover an operand.
    localparam int IDX_W = $clog2(NUM_REQ);

    state_t               state;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     grant;
    logic [IDX_W-1:0]     winner;
    logic                 lo_eq;
    logic                 eq_r;
    logic [OP_WIDTH-1:0]  a_arr [NUM_REQ];
    logic [OP_WIDTH-1:0]  b_arr [NUM_REQ];
    logic [CMP_WIDTH-1:0] cmp_a;
    logic [CMP_WIDTH-1:0] cmp_b;
    logic                 cmp_eq;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i] = a_flat[i*OP_WIDTH +: OP_WIDTH];
        assign b_arr[i] = b_flat[i*OP_WIDTH +: OP_WIDTH];
    end

    // Scan from the farthest offset back to ptr so the nearest set request wins.
    always_comb begin
        logic [IDX_W:0] idx;
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        winner = ptr;
        idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (IDX_W+1)'(k);
            if (idx >= (IDX_W+1)'(NUM_REQ))
                idx = idx - (IDX_W+1)'(NUM_REQ);
            if (req[idx[IDX_W-1:0]])
                winner = idx[IDX_W-1:0];
        end
    end

    always_comb begin
        if (state == HI) begin
            cmp_a = a_arr[grant][OP_WIDTH-1:CMP_WIDTH];
            cmp_b = b_arr[grant][OP_WIDTH-1:CMP_WIDTH];
        end else begin
            cmp_a = a_arr[grant][CMP_WIDTH-1:0];
            cmp_b = b_arr[grant][CMP_WIDTH-1:0];
        end
    end

    cmp_arbiter_cmp #(
        .WIDTH (CMP_WIDTH)
    ) u_cmp (
        .a  (cmp_a),
        .b  (cmp_b),
        .eq (cmp_eq)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ptr   <= '0;
            grant <= '0;
            lo_eq <= 1'b0;
            eq_r  <= 1'b0;
            done  <= '0;
            eq    <= 1'b0;
            busy  <= 1'b0;
        end else begin
            done <= '0;
            eq   <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant <= winner;
                        busy  <= 1'b1;
                        state <= LO;
                    end
                end
                LO: begin
                    lo_eq <= cmp_eq;
`ifdef CMP_EARLY_OUT_EN
                    if (!cmp_eq) begin
                        eq_r  <= 1'b0;
                        state <= DONE;
                    end else begin
                        state <= HI;
                    end
`else
                    state <= HI;
`endif
                end
                HI: begin
                    eq_r  <= lo_eq & cmp_eq;
                    state <= DONE;
                end
                DONE: begin
                    done[grant] <= 1'b1;
                    eq          <= eq_r;
                    ptr         <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb_cmp_arbiter: directed stimulus against a transaction-level model of the
// comparator arbiter, compared every cycle, plus hand-computed checks.
module tb_cmp_arbiter;

    localparam int N   = 4;
    localparam int OPW = 64;
    localparam int CW  = 32;
`ifdef CMP_EARLY_OUT_EN
    localparam int LAT_LO_MISS = 2;
`else
    localparam int LAT_LO_MISS = 3;
`endif

    logic           clk   = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req   = '0;
    logic [OPW-1:0] a_op [N];
    logic [OPW-1:0] b_op [N];
    logic [N*OPW-1:0] a_flat;
    logic [N*OPW-1:0] b_flat;
    logic [N-1:0]   done;
    logic           eq;
    logic           busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_flat[i*OPW +: OPW] = a_op[i];
            b_flat[i*OPW +: OPW] = b_op[i];
        end
    end

    cmp_arbiter #(
        .NUM_REQ   (N),
        .OP_WIDTH  (OPW),
        .CMP_WIDTH (CW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .a_flat (a_flat),
        .b_flat (b_flat),
        .done   (done),
        .eq     (eq),
        .busy   (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a countdown to completion per granted transaction.
    int           m_cnt    = 0;
    int           m_grant  = 0;
    int           m_ptr    = 0;
    bit           m_eq     = 1'b0;
    logic [N-1:0] exp_done = '0;
    logic         exp_eq   = 1'b0;
    logic         exp_busy = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_cnt = 0; m_ptr = 0; m_grant = 0;
                exp_done = '0; exp_eq = 1'b0; exp_busy = 1'b0;
            end else begin
                exp_done = '0;
                exp_eq   = 1'b0;
                if (m_cnt > 0) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        exp_done[m_grant] = 1'b1;
                        exp_eq   = m_eq;
                        m_ptr    = (m_grant + 1) % N;
                        exp_busy = 1'b0;
                    end
                end else if (req != '0) begin
                    for (int k = 0; k < N; k++) begin
                        if (req[(m_ptr + k) % N]) begin
                            m_grant = (m_ptr + k) % N;
                            break;
                        end
                    end
                    m_eq = (a_op[m_grant] == b_op[m_grant]);
`ifdef CMP_EARLY_OUT_EN
                    m_cnt = (a_op[m_grant][CW-1:0] != b_op[m_grant][CW-1:0]) ? 2 : 3;
`else
                    m_cnt = 3;
`endif
                    exp_busy = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("mon_done", done, exp_done);
                check("mon_eq", eq, exp_eq);
                check("mon_busy", busy, exp_busy);
            end
        end
    end

    task automatic run_txn(input string name, input logic [N-1:0] r, input int exp_lat,
                           input logic [N-1:0] exp_d, input logic exp_e, input bit drop_in_lo);
        int cyc;
        bit seen;
        @(negedge clk);
        req  = r;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check({name, "_busy"}, busy, 1);
                if (drop_in_lo) req = '0;
            end
            if (done != '0) begin
                seen = 1'b1;
                check({name, "_lat"}, cyc - 1, exp_lat);
                check({name, "_done"}, done, exp_d);
                check({name, "_eq"}, eq, exp_e);
            end
        end
        check({name, "_seen"}, seen, 1);
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int order [$];
        int when [$];
        int exp_ord [5] = '{0, 1, 2, 3, 0};

        for (int i = 0; i < N; i++) begin
            a_op[i] = '0;
            b_op[i] = '0;
        end
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        check("rst_done", done, 0);
        check("rst_eq", eq, 0);
        check("rst_busy", busy, 0);
        #2 reset = 1'b1;

        a_op[0] = 64'h0123_4567_89AB_CDEF; b_op[0] = 64'h0123_4567_89AB_CDEF;
        run_txn("t1_equal", 4'b0001, 3, 4'b0001, 1'b1, 1'b0);

        a_op[1] = 64'h0; b_op[1] = 64'h8000_0000_0000_0000;
        run_txn("t2_hi_miss", 4'b0010, 3, 4'b0010, 1'b0, 1'b0);

        a_op[0] = 64'h0; b_op[0] = 64'h1;
        run_txn("t3_lo_miss", 4'b0001, LAT_LO_MISS, 4'b0001, 1'b0, 1'b0);

        a_op[0] = 64'hDEAD_BEEF_0000_1234; b_op[0] = 64'hDEAD_BEEF_0000_1234;
        run_txn("t4_drop", 4'b0001, 3, 4'b0001, 1'b1, 1'b1);
        check("t4_no_retry_busy", busy, 0);
        check("t4_no_retry_done", done, 0);

        // Reset pulse so the round-robin pointer starts from requester 0.
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;

        for (int i = 0; i < N; i++) begin
            a_op[i] = 64'h5555_AAAA_0F0F_F0F0;
            b_op[i] = 64'h5555_AAAA_0F0F_F0F0;
        end
        @(negedge clk);
        req = 4'b1111;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (done[i]) begin
                    order.push_back(i);
                    when.push_back(c);
                end
            end
        end
        req = '0;
        check("rr_count", order.size(), 5);
        for (int i = 0; i < order.size() && i < 5; i++)
            check($sformatf("rr_order%0d", i), order[i], exp_ord[i]);
        for (int i = 1; i < when.size(); i++)
            check($sformatf("rr_gap%0d", i), when[i] - when[i-1], 4);
        repeat (2) @(negedge clk);

        a_op[2] = 64'h1111_2222_3333_4444; b_op[2] = 64'h1111_2222_3333_4444;
        a_op[3] = 64'h9999_8888_7777_6666; b_op[3] = 64'h9999_8888_7777_6666;
        @(negedge clk);
        req = 4'b0100;
        @(negedge clk);
        check("t6_busy_lo", busy, 1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("t6_abort_busy", busy, 0);
        check("t6_abort_done", done, 0);
        check("t6_abort_eq", eq, 0);
        req = '0;
        @(negedge clk);
        check("t6_no_done", done, 0);
        #2 reset = 1'b1;
        run_txn("t6_after_rst", 4'b1100, 3, 4'b0100, 1'b1, 1'b0);

        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cmp_arbiter.md
CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the comparator (2..8).
REQ-002 Parameter OP_WIDTH, default 64: operand width per requester.
REQ-003 Parameter CMP_WIDTH, default 32: width of the shared equality comparator; OP_WIDTH SHALL equal 2*CMP_WIDTH.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req  input  NUM_REQ  per-requester compare request, level, held until its done pulse.
REQ-007 a_flat  input  NUM_REQ*OP_WIDTH  operand A of requester i at bits [i*OP_WIDTH +: OP_WIDTH].
REQ-008 b_flat  input  NUM_REQ*OP_WIDTH  operand B, same packing.
REQ-009 done  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-010 eq  output  1  compare result, valid only while any done bit is high.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, LO, HI, DONE.
REQ-013 IDLE: if any req bit is high, latch winner into grant and go to LO; else stay IDLE.
REQ-014 Arbitration SHALL be round-robin: search from ptr upward, wrapping at NUM_REQ-1 to 0; first set req bit wins.
REQ-015 LO: feed A/B bits [CMP_WIDTH-1:0] of grant to the comparator, register result in lo_eq, go to HI.
REQ-016 HI: feed bits [OP_WIDTH-1:CMP_WIDTH], register lo_eq AND comparator result into eq_r, go to DONE.
REQ-017 DONE: done[grant]=1, eq=eq_r, ptr <= (grant+1) mod NUM_REQ, go to IDLE.
REQ-018 Latency: done SHALL assert exactly 3 cycles after the edge that leaves IDLE (2 with early-out, REQ-026).
REQ-019 Operands SHALL be sampled live in LO and HI; the requester holds them stable until done.
REQ-020 A req deasserted mid-transaction SHALL NOT abort it; done still pulses to the latched grant.
REQ-021 A req still high in the IDLE cycle after DONE SHALL be re-arbitrated as a new transaction.
REQ-022 New requests arriving while busy SHALL be ignored until IDLE; at most one done bit is ever high.
REQ-023 eq SHALL be 0 whenever no done bit is high.

Reset
REQ-024 On reset low: state=IDLE, ptr=0, grant=0, lo_eq=0, eq_r=0, done=0, eq=0, busy=0, immediately and asynchronously.
REQ-025 Reset asserted mid-transaction SHALL abort it with no done pulse; arbitration restarts from requester 0.

Configuration
REQ-026 With CMP_EARLY_OUT_EN defined, an LO mismatch SHALL go LO->DONE with eq_r=0, skipping HI; without it, HI is always visited and latency is fixed at 3.

Structure
REQ-027 Package cmp_arb_pkg SHALL hold the state encodings (IDLE=2'd0, LO=2'd1, HI=2'd2, DONE=2'd3) and the default width constants.
REQ-028 One sub-module: the existing compare block, instantiated once with WIDTH=CMP_WIDTH and driven by the operand mux; round-robin logic stays inline.

Verification
REQ-029 req=4'b0001, A=B=64'h0123_4567_89AB_CDEF -> busy next cycle, done=4'b0001 with eq=1 three cycles after grant edge.
REQ-030 req=4'b0010, A=64'h0, B=64'h8000_0000_0000_0000 -> done[1] after 3 cycles, eq=0 (with or without early-out).
REQ-031 req=4'b0001, A=64'h0, B=64'h1 -> with CMP_EARLY_OUT_EN done[0] after 2 cycles, eq=0; without it after 3 cycles, eq=0.
REQ-032 req=4'b1111 held 20 cycles, all operands equal -> done order 0,1,2,3,0 with one IDLE cycle between transactions.
REQ-033 req=4'b0100, reset pulsed low during HI -> no done pulse, busy=0 at once; then req=4'b1100 -> requester 2 granted first (ptr=0).
REQ-034 req=4'b0001 dropped during LO -> done[0] still pulses at cycle 3, no second transaction follows.
